fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one outstanding word fetch at a time and buffers
// returned instructions in a 2-entry FIFO presented to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc_plus4
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    fpc_q, fpc_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]    fifo_pc_q [DEPTH];
  logic [XLEN-1:0]    fifo_pc_d [DEPTH];
  logic [XLEN-1:0]    fifo_instr_q [DEPTH];
  logic [XLEN-1:0]    fifo_instr_d [DEPTH];

  logic req_c;
  logic grant_c;
  logic push_c;
  logic pop_c;
  logic unused_redirect_lo;

  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Next-state: fetch sequencing, FIFO push/pop, redirect flush overriding everything
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    pend_pc_d    = pend_pc_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    req_c   = (state_q == ST_REQ) && (cnt_q < CNT_W'(DEPTH));
    grant_c = req_c && imem_gnt;
    push_c  = (state_q == ST_WAIT) && imem_rvalid;
    pop_c   = (cnt_q != '0) && d_ready;

    unique case (state_q)
      ST_REQ: begin
        if (grant_c) begin
          pend_pc_d = fpc_q;
          fpc_d     = fpc_q + XLEN'(4);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT, ST_DRAIN: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect) begin
      fpc_d    = {redirect_pc[31:2], 2'b00};
      cnt_d    = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      // A response still owed by memory must be swallowed before fetching again
      state_d  = (grant_c || ((state_q != ST_REQ) && !imem_rvalid)) ? ST_DRAIN : ST_REQ;
    end else begin
      if (push_c) begin
        fifo_pc_d[wr_ptr_q]    = pend_pc_q;
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REQ;
      fpc_q        <= RESET_PC;
      pend_pc_q    <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      pend_pc_q    <= pend_pc_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  // Reset gating keeps the interface quiet for the whole reset window
  assign imem_req   = !reset && req_c;
  assign imem_addr  = fpc_q;
  assign d_valid    = !reset && (cnt_q != '0);
  assign d_instr    = d_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign d_pc       = d_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign d_pc_plus4 = d_valid ? (fifo_pc_q[rd_ptr_q] + XLEN'(4)) : '0;

endmodule
